// File: rtl/accum_seq_pkg.sv
// Shared widths and FSM state encoding for the step-accumulator sequencer.
package accum_seq_pkg;

  localparam int unsigned ACC_W_DEF  = 16;
  localparam int unsigned STEP_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    OUT_HI = 2'd2,
    OUT_LO = 2'd3
  } state_e;

endpackage

// File: rtl/accum_seq_ctrl_dp.sv
// Accumulator register: synchronous load-zero, enable-add of a zero-extended step, carry out.
module accum_dp
  import accum_seq_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  output logic [ACC_W-1:0]  acc,
  output logic              carry_c,
  output logic [7:0]        sum_hi_c
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] ext_sum;

  assign ext_sum  = {1'b0, acc} + SUM_W'(step);
  assign carry_c  = ext_sum[ACC_W];
  assign sum_hi_c = ext_sum[ACC_W-1 -: 8];

  // clr has priority so an accept with clear never adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= ext_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/accum_seq_ctrl.sv
// Command sequencer: runs cmd_count accumulate cycles, then returns the result MSB byte first.
module accum_seq_ctrl
  import accum_seq_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              cmd_clear,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_data,
  output logic              busy,
  output logic              ovf,
  output logic [7:0]        acc_hi
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_OUT_HI = OUT_HI;
  localparam logic [1:0] ST_OUT_LO = OUT_LO;

  logic [1:0]        state, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  remaining, remaining_d;
  logic              ovf_d;
  logic [7:0]        res_data_d;
  logic              dp_clr, dp_en;
  logic [ACC_W-1:0]  acc;
  logic              carry_c;
  logic [7:0]        sum_hi_c;

  accum_dp #(
    .ACC_W  (ACC_W),
    .STEP_W (STEP_W)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (dp_clr),
    .en       (dp_en),
    .step     (step_q),
    .acc      (acc),
    .carry_c  (carry_c),
    .sum_hi_c (sum_hi_c)
  );

  assign acc_hi = acc[ACC_W-1 -: 8];

  // State, operands and all handshake outputs are registered from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      step_q    <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      step_q    <= step_d;
      remaining <= remaining_d;
      ovf       <= ovf_d;
      cmd_ready <= (state_d == ST_IDLE);
      res_valid <= (state_d == ST_OUT_HI) || (state_d == ST_OUT_LO);
      res_data  <= res_data_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Next-state, datapath control and the byte that will be presented next cycle.
  always_comb begin
    state_d     = state;
    step_d      = step_q;
    remaining_d = remaining;
    ovf_d       = ovf;
    res_data_d  = 8'h00;
    dp_clr      = 1'b0;
    dp_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          step_d      = cmd_step;
          remaining_d = cmd_count;
          ovf_d       = 1'b0;
          dp_clr      = cmd_clear;
          if (cmd_count != '0) begin
            state_d = ST_RUN;
          end else begin
            state_d    = ST_OUT_HI;
            res_data_d = cmd_clear ? 8'h00 : acc[ACC_W-1 -: 8];
          end
        end
      end
      ST_RUN: begin
        dp_en       = 1'b1;
        remaining_d = remaining - CNT_W'(1);
        if (carry_c) begin
          ovf_d = 1'b1;
        end
        if (remaining == CNT_W'(1)) begin
          state_d    = ST_OUT_HI;
          res_data_d = sum_hi_c;
        end
      end
      ST_OUT_HI: begin
        if (res_ready) begin
          state_d    = ST_OUT_LO;
          res_data_d = acc[7:0];
        end else begin
          res_data_d = acc[ACC_W-1 -: 8];
        end
      end
      ST_OUT_LO: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          res_data_d = acc[7:0];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed bench for accum_seq_ctrl with a byte scoreboard fed by a reference accumulator.
module tb_accum_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_step;
  logic [7:0] cmd_count;
  logic       cmd_clear;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;
  logic       ovf;
  logic [7:0] acc_hi;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] m_acc = 16'h0000;
  logic        m_ovf = 1'b0;

  accum_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_step  (cmd_step),
    .cmd_count (cmd_count),
    .cmd_clear (cmd_clear),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .ovf       (ovf),
    .acc_hi    (acc_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference model for one accepted command; pushes the two expected bytes.
  task automatic push_expect(input logic [7:0] step, input logic [7:0] count, input logic clear);
    logic [16:0] s;
    if (clear) m_acc = 16'h0000;
    m_ovf = 1'b0;
    for (int i = 0; i < int'(count); i++) begin
      s = {1'b0, m_acc} + 17'(step);
      if (s[16]) m_ovf = 1'b1;
      m_acc = s[15:0];
    end
    exp_q.push_back(m_acc[15:8]);
    exp_q.push_back(m_acc[7:0]);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic send_cmd(input logic [7:0] step, input logic [7:0] count, input logic clear,
                          input bit push, input bit hold);
    check("cmd_ready_before_accept", 16'(cmd_ready), 16'h1);
    cmd_step  = step;
    cmd_count = count;
    cmd_clear = clear;
    cmd_valid = 1'b1;
    if (push) push_expect(step, count, clear);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Takes both result bytes with res_ready high; returns at the first idle negedge.
  task automatic get_result();
    res_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      int t = 0;
      while (!res_valid && t < 400) begin
        @(negedge clk);
        t++;
      end
      check("res_valid_seen", 16'(res_valid), 16'h1);
      if (exp_q.size() != 0) check(b == 0 ? "res_hi" : "res_lo", 16'(res_data), 16'(exp_q.pop_front()));
      @(negedge clk);
    end
    check("res_valid_after", 16'(res_valid), 16'h0);
    check("res_data_idle", 16'(res_data), 16'h0);
    check("cmd_ready_idle", 16'(cmd_ready), 16'h1);
    check("ovf", 16'(ovf), 16'(m_ovf));
  endtask

  initial begin
    logic [7:0] hi_tab [5];
    hi_tab = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02};
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_step  = 8'h00;
    cmd_count = 8'h00;
    cmd_clear = 1'b0;
    res_ready = 1'b0;
    #12;
    check("rst_cmd_ready", 16'(cmd_ready), 16'h1);
    check("rst_res_valid", 16'(res_valid), 16'h0);
    check("rst_res_data", 16'(res_data), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_ovf", 16'(ovf), 16'h0);
    check("rst_acc_hi", 16'(acc_hi), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: step 3 x 4 from clear
    res_ready = 1'b1;
    send_cmd(8'h03, 8'h04, 1'b1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_busy", 16'(busy), 16'h1);
      check("t1_res_valid", 16'(res_valid), 16'h0);
      check("t1_acc_hi", 16'(acc_hi), 16'h0);
      @(negedge clk);
    end
    check("t1_res_valid_rise", 16'(res_valid), 16'h1);
    get_result();

    // 2: zero count goes straight to output
    send_cmd(8'h55, 8'h00, 1'b1, 1, 0);
    check("t2_res_valid_now", 16'(res_valid), 16'h1);
    check("t2_acc_hi", 16'(acc_hi), 16'h0);
    get_result();

    // 3: long runs, second one carries out
    send_cmd(8'hFF, 8'hFF, 1'b1, 1, 0);
    get_result();
    send_cmd(8'hFF, 8'hFF, 1'b0, 1, 0);
    get_result();
    check("t3_acc_model", m_acc, 16'hFC02);

    // 4: backpressure in OUT_HI with an ignored command
    res_ready = 1'b0;
    send_cmd(8'h90, 8'h03, 1'b1, 1, 0);
    for (int t = 0; t < 20 && !res_valid; t++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", 16'(res_valid), 16'h1);
      check("t4_hold_data", 16'(res_data), 16'(exp_q[0]));
      check("t4_cmd_ready", 16'(cmd_ready), 16'h0);
      cmd_valid = (i == 4);
      cmd_step  = 8'h11;
      cmd_count = 8'h01;
      cmd_clear = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    get_result();
    @(negedge clk);
    check("t4_no_queued_cmd", 16'(busy), 16'h0);

    // 5: reset mid-run aborts and clears acc
    send_cmd(8'h07, 8'd20, 1'b1, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", 16'(busy), 16'h0);
    check("t5_res_valid", 16'(res_valid), 16'h0);
    check("t5_res_data", 16'(res_data), 16'h0);
    check("t5_acc_hi", 16'(acc_hi), 16'h0);
    check("t5_ovf", 16'(ovf), 16'h0);
    check("t5_cmd_ready", 16'(cmd_ready), 16'h1);
    m_acc = 16'h0000;
    m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_cmd(8'h01, 8'h02, 1'b0, 1, 0);
    get_result();

    // 6: back-to-back with cmd_valid held, acc_hi visible during RUN
    send_cmd(8'h80, 8'h04, 1'b1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      check("t6_acc_hi", 16'(acc_hi), 16'(hi_tab[i]));
      if (i < 4) @(negedge clk);
    end
    get_result();
    check("t6_bubble_busy", 16'(busy), 16'h0);
    push_expect(8'h80, 8'h04, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t6_second_accept", 16'(busy), 16'h1);
    get_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
